// File: rtl/mjpg_packetizer.sv
// MJPEG packetizer: takes a byte-stuffed JPEG byte stream, buffers it in a
// FIFO and emits packets of the form 02, {1,000000,fid}, payload... on a
// valid/ready stream. A new packet is started at every SOI marker (FF D8),
// when the payload limit is reached, or when the encoder goes idle.
module mjpg_packetizer #(
  parameter int DEPTH        = 2048,
  parameter int MAX_PAYLOAD  = 1020,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jvalid,
  input  logic [7:0]  jpeg,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

  // Input stage: one byte of look-behind so FF D8 can be tagged on the FF.
  logic        hold_v_reg;
  logic [7:0]  hold_d_reg;
  logic [15:0] idle_cnt_reg;
  logic        overflow_reg;

  // FIFO of {sof, data}
  logic [8:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [8:0]    head;
  logic [8:0]    head1;

  // Output side
  state_t        state_reg;
  state_t        state_next;
  logic          fid_reg;
  logic [10:0]   pay_cnt_reg;
  logic [15:0]   frame_cnt_reg;
  logic          last_hold_reg;

  logic       flush;
  logic       push_req;
  logic       push_ok;
  logic [8:0] push_data;
  logic       fifo_full;
  logic       fifo_nonempty;
  logic       cnt_ge2;
  logic       last_cond;
  logic       pop;

  assign flush         = !jvalid && hold_v_reg && (idle_cnt_reg == 16'(IDLE_TIMEOUT - 1));
  assign push_req      = (jvalid && hold_v_reg) || flush;
  assign push_data     = jvalid ? {(hold_d_reg == 8'hFF) && (jpeg == 8'hD8), hold_d_reg}
                                : {1'b0, hold_d_reg};
  assign fifo_full     = (count_reg == CW'(DEPTH));
  assign fifo_nonempty = (count_reg != '0);
  assign cnt_ge2       = (count_reg >= CW'(2));
  assign push_ok       = push_req && !fifo_full;

  assign head  = fifo_mem[rd_ptr_reg];
  assign head1 = fifo_mem[rd_ptr_reg + AW'(1)];

  // Packet ends at the payload limit, just before the next SOI, or when the
  // stream has gone idle and this is the only byte left.
  assign last_cond = (pay_cnt_reg == 11'(MAX_PAYLOAD - 1))
                  || (cnt_ge2 && head1[8])
                  || ((count_reg == CW'(1)) && !hold_v_reg && (idle_cnt_reg == 16'(IDLE_TIMEOUT)));

  assign pop = (state_reg == PAYLOAD) && m_valid && m_ready;

  assign overflow  = overflow_reg;
  assign frame_cnt = frame_cnt_reg;

  // Hold register, idle counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_reg   <= 1'b0;
      hold_d_reg   <= 8'h00;
      idle_cnt_reg <= 16'h0000;
      overflow_reg <= 1'b0;
    end else begin
      if (jvalid) begin
        hold_v_reg   <= 1'b1;
        hold_d_reg   <= jpeg;
        idle_cnt_reg <= 16'h0000;
      end else begin
        if (idle_cnt_reg != 16'(IDLE_TIMEOUT))
          idle_cnt_reg <= idle_cnt_reg + 16'h0001;
        if (flush)
          hold_v_reg <= 1'b0;
      end
      if (push_req && fifo_full)
        overflow_reg <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fifo_nonempty) state_next = HDR0;
      HDR0:    if (m_ready) state_next = HDR1;
      HDR1:    if (m_ready) state_next = PAYLOAD;
      PAYLOAD: if (m_valid && m_ready && m_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; a presented m_last is held until accepted
  always_comb begin
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    case (state_reg)
      HDR0: begin
        m_valid = 1'b1;
        m_data  = 8'h02;
      end
      HDR1: begin
        m_valid = 1'b1;
        m_data  = {1'b1, 6'b000000, fid_reg};
      end
      PAYLOAD: begin
        m_data  = head[7:0];
        m_last  = last_cond || last_hold_reg;
        m_valid = cnt_ge2 || m_last;
      end
      default: ;
    endcase
  end

  // FID toggle at packet start, payload and frame counters, held-last flag
  always_ff @(posedge clk) begin
    if (rst) begin
      fid_reg       <= 1'b0;
      pay_cnt_reg   <= 11'd0;
      frame_cnt_reg <= 16'h0000;
      last_hold_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && fifo_nonempty)
        fid_reg <= fid_reg ^ head[8];
      if (pop) begin
        if (head[8])
          frame_cnt_reg <= frame_cnt_reg + 16'h0001;
        if (m_last) begin
          pay_cnt_reg   <= 11'd0;
          last_hold_reg <= 1'b0;
        end else begin
          pay_cnt_reg <= pay_cnt_reg + 11'd1;
        end
      end else if (state_reg == PAYLOAD && m_valid && m_last) begin
        last_hold_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mjpg_packetizer.sv
// Scoreboard bench for mjpg_packetizer: two instances (default payload limit
// and a 4-byte limit), small FIFO and short idle timeout.
module tb_mjpg_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        jvalid_a, jvalid_b;
  logic [7:0]  jpeg_a, jpeg_b;
  logic        m_ready_a, m_ready_b;
  logic        m_valid_a, m_valid_b;
  logic [7:0]  m_data_a, m_data_b;
  logic        m_last_a, m_last_b;
  logic        overflow_a, overflow_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;

  mjpg_packetizer #(.DEPTH(16), .MAX_PAYLOAD(1020), .IDLE_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .jvalid(jvalid_a), .jpeg(jpeg_a),
    .m_valid(m_valid_a), .m_data(m_data_a), .m_last(m_last_a), .m_ready(m_ready_a),
    .overflow(overflow_a), .frame_cnt(frame_cnt_a));

  mjpg_packetizer #(.DEPTH(16), .MAX_PAYLOAD(4), .IDLE_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .jvalid(jvalid_b), .jpeg(jpeg_b),
    .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready_b),
    .overflow(overflow_b), .frame_cnt(frame_cnt_b));

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] e_a, e_b;
  int xfer_a = 0;
  bit last_seen_a = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor A: every accepted beat is compared with the scoreboard head
  always @(negedge clk) begin
    if (!rst && m_valid_a && m_ready_a) begin
      xfer_a++;
      if (m_last_a) last_seen_a = 1'b1;
      $display("a xfer data=%02h last=%0d", m_data_a, m_last_a);
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got %03h want none", {m_last_a, m_data_a});
      end else begin
        e_a = exp_a.pop_front();
        check("a_beat", int'({m_last_a, m_data_a}), int'(e_a));
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst && m_valid_b && m_ready_b) begin
      $display("b xfer data=%02h last=%0d", m_data_b, m_last_b);
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got %03h want none", {m_last_b, m_data_b});
      end else begin
        e_b = exp_b.pop_front();
        check("b_beat", int'({m_last_b, m_data_b}), int'(e_b));
      end
    end
  end

  task automatic expect_beat(input bit sel, input bit last, input logic [7:0] d);
    if (sel) exp_b.push_back({last, d});
    else     exp_a.push_back({last, d});
  endtask

  task automatic drive(input bit sel, input logic [7:0] b);
    if (sel) begin jvalid_b = 1'b1; jpeg_b = b; end
    else     begin jvalid_a = 1'b1; jpeg_a = b; end
    @(posedge clk); #1;
    jvalid_a = 1'b0;
    jvalid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input bit sel, input int budget);
    int k = 0;
    while ((sel ? exp_b.size() : exp_a.size()) != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(sel ? "b_drain_left" : "a_drain_left", sel ? exp_b.size() : exp_a.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [7:0] seq [$];
    rst = 1'b1;
    jvalid_a = 1'b0; jvalid_b = 1'b0; jpeg_a = 8'h00; jpeg_b = 8'h00;
    m_ready_a = 1'b0; m_ready_b = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state after 10 quiet cycles
    idle(10);
    @(negedge clk);
    check("rst_m_valid_a", m_valid_a, 0);
    check("rst_overflow_a", overflow_a, 0);
    check("rst_frame_cnt_a", frame_cnt_a, 0);
    check("rst_m_valid_b", m_valid_b, 0);

    // Idle flush: one packet 02 81 FF D8 00..09
    m_ready_a = 1'b1;
    expect_beat(0, 0, 8'h02); expect_beat(0, 0, 8'h81);
    expect_beat(0, 0, 8'hFF); expect_beat(0, 0, 8'hD8);
    for (int i = 0; i < 10; i++) expect_beat(0, i == 9, 8'(i));
    drive(0, 8'hFF); drive(0, 8'hD8);
    for (int i = 0; i < 10; i++) drive(0, 8'(i));
    drain(0, 100);
    idle(2);
    @(negedge clk);
    check("flush_frame_cnt", frame_cnt_a, 1);
    check("flush_overflow", overflow_a, 0);

    // Payload limit of 4: three packets, all FID 1
    m_ready_b = 1'b1;
    seq = '{8'hFF, 8'hD8, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin expect_beat(1, 0, 8'h02); expect_beat(1, 0, 8'h81); end
      expect_beat(1, i % 4 == 3, seq[i]);
    end
    for (int i = 0; i < 12; i++) drive(1, seq[i]);
    drain(1, 100);
    idle(2);
    @(negedge clk);
    check("limit_frame_cnt", frame_cnt_b, 1);

    // Frame change: second SOI starts a new packet with FID 0
    do_reset();
    expect_beat(0, 0, 8'h02); expect_beat(0, 0, 8'h81);
    expect_beat(0, 0, 8'hFF); expect_beat(0, 0, 8'hD8);
    expect_beat(0, 0, 8'h20); expect_beat(0, 0, 8'h21); expect_beat(0, 1, 8'h22);
    expect_beat(0, 0, 8'h02); expect_beat(0, 0, 8'h80);
    expect_beat(0, 0, 8'hFF); expect_beat(0, 0, 8'hD8);
    expect_beat(0, 0, 8'h30); expect_beat(0, 1, 8'h31);
    seq = '{8'hFF, 8'hD8, 8'h20, 8'h21, 8'h22, 8'hFF, 8'hD8, 8'h30, 8'h31};
    for (int i = 0; i < 9; i++) drive(0, seq[i]);
    drain(0, 100);
    idle(2);
    @(negedge clk);
    check("frame_change_cnt", frame_cnt_a, 2);

    // Backpressure and overflow: 19 bytes into a 16-deep FIFO
    do_reset();
    m_ready_a = 1'b0;
    expect_beat(0, 0, 8'h02); expect_beat(0, 0, 8'h80);
    for (int i = 0; i < 16; i++) expect_beat(0, i == 15, 8'(8'h40 + i));
    for (int i = 0; i < 19; i++) drive(0, 8'(8'h40 + i));
    idle(12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_m_valid", m_valid_a, 1);
      check("bp_m_data", m_data_a, 8'h02);
      check("bp_m_last", m_last_a, 0);
    end
    check("bp_overflow", overflow_a, 1);
    @(posedge clk); #1;
    base = xfer_a;
    m_ready_a = 1'b1;
    drain(0, 100);
    idle(4);
    check("bp_beats", xfer_a - base, 18);

    // Reset after three payload transfers
    do_reset();
    last_seen_a = 1'b0;
    m_ready_a = 1'b1;
    expect_beat(0, 0, 8'h02); expect_beat(0, 0, 8'h81);
    expect_beat(0, 0, 8'hFF); expect_beat(0, 0, 8'hD8); expect_beat(0, 0, 8'h60);
    base = xfer_a;
    seq = '{8'hFF, 8'hD8, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    for (int i = 0; i < 12; i++) begin
      drive(0, seq[i]);
      if (xfer_a - base >= 5) break;
    end
    check("midrst_beats_before", xfer_a - base, 5);
    rst = 1'b1;
    m_ready_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid_a, 0);
    check("midrst_frame_cnt", frame_cnt_a, 0);
    check("midrst_last_seen", last_seen_a, 0);
    check("midrst_queue_left", exp_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mjpg_packetizer.md
MJPG_PACKETIZER -- requirements
Module: mjpg_packetizer

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning FIFO capacity in bytes; power of two, 16 or more.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1020, meaning maximum payload bytes per packet, excluding header; range 2..2047.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 256, meaning the number of jvalid-low cycles before a flush; range 2..65535.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port jvalid, input, 1 bit: JPEG byte strobe from the encoder; no backpressure is possible.
REQ-007 SHALL have port jpeg, input, 8 bits: JPEG byte, already byte-stuffed.
REQ-008 SHALL have port m_valid, output, 1 bit: packet byte valid.
REQ-009 SHALL have port m_data, output, 8 bits: packet byte.
REQ-010 SHALL have port m_last, output, 1 bit: final byte of the packet.
REQ-011 SHALL have port m_ready, input, 1 bit: sink accepts; a transfer occurs when m_valid & m_ready.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag; a byte was dropped.
REQ-013 SHALL have port frame_cnt, output, 16 bits: count of SOF bytes emitted; wraps.

Function
REQ-014 Input stage SHALL hold one byte (hold_v, hold_d) to detect SOI: on jvalid with hold_v=1, SHALL push {sof, hold_d} into the FIFO with sof = (hold_d==8'hFF && jpeg==8'hD8), then load jpeg into hold.
REQ-015 On jvalid with hold_v=0, SHALL load hold only; no push.
REQ-016 idle_cnt SHALL clear on jvalid and otherwise increment, saturating at IDLE_TIMEOUT.
REQ-017 When idle_cnt==IDLE_TIMEOUT-1, jvalid=0 and hold_v=1, SHALL push {0, hold_d} and clear hold_v.
REQ-018 A push with the FIFO full SHALL drop the byte and set overflow; the hold register is still updated.
REQ-019 FIFO SHALL be 9 bits wide with DEPTH entries and SHALL expose both the head and head+1 entries combinationally.
REQ-020 FIFO push and pop in the same cycle SHALL both take effect; the count is unchanged.
REQ-021 Output FSM SHALL have states IDLE, HDR0, HDR1 and PAYLOAD.
REQ-022 In IDLE, SHALL go to HDR0 when the FIFO is non-empty, latching the packet FID as fid ^ head.sof, and updating fid to that value.
REQ-023 HDR0 SHALL drive m_data=8'h02, m_valid=1, m_last=0, and advance on transfer.
REQ-024 HDR1 SHALL drive m_data={1'b1,6'b0,fid}, m_valid=1, m_last=0, and advance on transfer.
REQ-025 In PAYLOAD, m_data SHALL be head.data.
REQ-026 In PAYLOAD, m_last SHALL be 1 when any of these holds: pay_cnt==MAX_PAYLOAD-1; FIFO count 2 or more and (head+1).sof=1; FIFO count==1 and hold_v=0 and idle_cnt==IDLE_TIMEOUT.
REQ-027 In PAYLOAD, m_valid SHALL be 1 when FIFO count is 2 or more, or when m_last=1; otherwise m_valid=0 and the FSM waits.
REQ-028 A PAYLOAD transfer SHALL pop the FIFO and increment pay_cnt (11 bits).
REQ-029 A transfer with m_last=1 SHALL go to IDLE and clear pay_cnt.
REQ-030 A popped entry with sof=1 SHALL increment frame_cnt by 1, wrapping 16'hFFFF to 0.
REQ-031 An SOF byte SHALL only ever be the first payload byte of a packet.
REQ-032 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-033 Minimum latency SHALL be: jvalid byte N pushed one cycle after byte N+1 arrives; header is visible on m_* 2 cycles after the first push.

Reset
REQ-034 rst SHALL force: state=IDLE, m_valid=0, m_last=0, m_data=0, overflow=0, frame_cnt=0, fid=0, hold_v=0, idle_cnt=0, pay_cnt=0, and FIFO empty.
REQ-035 rst mid-packet SHALL abandon the packet without asserting m_last; the first byte after reset starts a fresh hold.
REQ-036 rst SHALL take priority over jvalid and m_ready in the same cycle.

Verification
REQ-037 Reset test: after rst with jvalid=0 for 10 cycles, SHALL read m_valid=0, overflow=0, frame_cnt=0.
REQ-038 Idle flush: send FF D8 plus 10 bytes (00..09), m_ready=1, then idle for IDLE_TIMEOUT cycles; SHALL see one packet 02,81,FF,D8,00..09 with m_last on 09, and frame_cnt=1.
REQ-039 Payload limit: with MAX_PAYLOAD=4, send 10 non-marker bytes after the SOI, then idle; SHALL see payloads of 4,4,4 bytes, each with header 02,81 after the first; FID stays 1.
REQ-040 Frame change: send a frame of 5 bytes then a second FF D8; SHALL see m_last on the byte preceding FF, then a packet with header 02,80 starting FF,D8, and frame_cnt=2.
REQ-041 Backpressure/overflow: hold m_ready=0 and send DEPTH+3 bytes; SHALL see overflow=1, m_data stable on header 02, and exactly DEPTH bytes delivered after m_ready=1.
REQ-042 Reset mid-packet: assert rst after 3 payload transfers; SHALL see m_valid=0 the next cycle, with no m_last seen, and frame_cnt=0.
